// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one Q-format fixed-point multiplier among NUM_REQ requesters.
// Optional: define MULT_ARB_SATURATE_EN to saturate the mantissa of overflowed products.
module mult_share_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int MULT_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic [15:0]           mult_a,
    output logic [15:0]           mult_b,
    output logic                  mult_en,
    input  logic [15:0]           mult_out,
    input  logic                  mult_ovf,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [15:0]           rsp_result,
    output logic                  rsp_overflow,
    output logic                  busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [15:0]     mult_a_q, mult_a_d;
    logic [15:0]     mult_b_q, mult_b_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [15:0]     rsp_result_q, rsp_result_d;
    logic            rsp_ovf_q, rsp_ovf_d;

    logic            found;
    int unsigned     gnt_idx;
    int unsigned     idx;
    logic [NUM_REQ-1:0] vshift;
    logic [15:0]     a_sel, b_sel;
    logic [15:0]     captured;

    // Scan from ptr upward, wrapping at NUM_REQ so unused indices are never granted.
    always_comb begin
        found   = 1'b0;
        gnt_idx = 0;
        idx     = 0;
        vshift  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            vshift = req_valid >> idx;
            if (!found && vshift[0]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        a_sel = 16'(req_a >> (16 * gnt_idx));
        b_sel = 16'(req_b >> (16 * gnt_idx));
    end

    always_comb begin
`ifdef MULT_ARB_SATURATE_EN
        if (mult_ovf)
            captured = {mult_out[15:13],
                        (mult_a_q[12] ^ mult_b_q[12]) ? 13'h1000 : 13'h0FFF};
        else
            captured = mult_out;
`else
        captured = mult_out;
`endif
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_ovf_d    = rsp_ovf_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx;
                    mult_a_d  = a_sel;
                    mult_b_d  = b_sel;
                    rsp_id_d  = ID_W'(gnt_idx);
                    ptr_d     = (gnt_idx + 1 >= NUM_REQ) ? '0 : ID_W'(gnt_idx + 1);
                    cnt_d     = 4'(MULT_LATENCY - 1);
                    state_d   = MUL;
                end
            end
            MUL: begin
                if (cnt_q == 4'd0) begin
                    rsp_result_d = captured;
                    rsp_ovf_d    = mult_ovf;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_ovf_q    <= rsp_ovf_d;
        end
    end

    assign mult_a       = mult_a_q;
    assign mult_b       = mult_b_q;
    assign mult_en      = (state_q == MUL);
    assign rsp_valid    = (state_q == RESP);
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_overflow = rsp_ovf_q;
    assign busy         = (state_q != IDLE);

endmodule
